// File: rtl/single_port_lutram_ctrl.sv
// Valid/ready write+read front end for single_port_lutram; zero-fills every set after reset, then arbitrates one access per cycle.
// Read ready drops when buffered + in-flight responses would exceed 2; optional SINGLE_PORT_LUTRAM_CTRL_WRITE_PRIORITY_EN gives writes fixed priority.

module single_port_lutram_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk_in,
  input  logic                       reset_in,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [WIDTH-1:0]           in_dat,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [WIDTH-1:0]           out_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slot [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // A full buffer still takes a push when the head leaves in the same cycle.
  assign out_vld = (count != '0);
  assign in_rdy  = (count != CW'(DEPTH)) || out_rdy;
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;
  assign out_dat = slot[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= in_dat;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

module single_port_lutram_ctrl #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUMBER_SET                = 64,
  parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUMBER_SET)
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  output logic                                 init_done_out,
  input  logic                                 write_req_valid_in,
  output logic                                 write_req_ready_out,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     write_req_addr_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_req_data_in,
  input  logic                                 read_req_valid_in,
  output logic                                 read_req_ready_out,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     read_req_addr_in,
  output logic                                 read_resp_valid_out,
  input  logic                                 read_resp_ready_in,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]     read_resp_addr_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_resp_data_out,
  output logic                                 mem_access_en_out,
  output logic                                 mem_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]     mem_set_addr_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem_write_entry_out,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem_read_entry_in
);
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     addr;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] data;
  } resp_t;
  localparam int RESP_W = $bits(resp_t);

  if ((NUMBER_SET & (NUMBER_SET - 1)) != 0) begin : g_bad_number_set
    $error("single_port_lutram_ctrl: NUMBER_SET must be a power of two");
  end

  logic [0:0]                       state_q;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] init_cnt_q;
  logic                             init_done_q;
  logic                             inflight_q;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] inflight_addr_q;
  logic [1:0]                       resp_count;
  logic                             resp_in_rdy;
  resp_t                            resp_push;
  resp_t                            resp_head;
  logic                             run;
  logic                             pop;
  logic [2:0]                       pending;
  logic                             read_ok;
  logic                             rd_cand;
  logic                             contested;
  logic                             grant_wr;
  logic                             grant_rd;

`ifndef SINGLE_PORT_LUTRAM_CTRL_WRITE_PRIORITY_EN
  localparam logic RR_WRITE = 1'b0;
  localparam logic RR_READ  = 1'b1;
  logic rr_q;
`endif

  // Gating with reset_in keeps requests out during a mid-run reset cycle.
  assign run       = (state_q == ST_RUN) && reset_in;
  assign pop       = read_resp_valid_out && read_resp_ready_in;
  assign pending   = {1'b0, resp_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign read_ok   = (pending < 3'd2);
  assign rd_cand   = run && read_req_valid_in && read_ok;
  assign contested = run && write_req_valid_in && rd_cand;

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (contested) begin
`ifdef SINGLE_PORT_LUTRAM_CTRL_WRITE_PRIORITY_EN
      grant_wr = 1'b1;
`else
      grant_wr = (rr_q == RR_WRITE);
      grant_rd = (rr_q == RR_READ);
`endif
    end else begin
      grant_wr = run && write_req_valid_in;
      grant_rd = rd_cand;
    end
  end

  assign write_req_ready_out = grant_wr;
  assign read_req_ready_out  = grant_rd;
  assign init_done_out       = init_done_q;

  always_comb begin
    mem_access_en_out   = 1'b0;
    mem_write_en_out    = 1'b0;
    mem_set_addr_out    = '0;
    mem_write_entry_out = '0;
    if (state_q == ST_INIT) begin
      mem_access_en_out = 1'b1;
      mem_write_en_out  = 1'b1;
      mem_set_addr_out  = init_cnt_q;
    end else if (grant_wr) begin
      mem_access_en_out   = 1'b1;
      mem_write_en_out    = 1'b1;
      mem_set_addr_out    = write_req_addr_in;
      mem_write_entry_out = write_req_data_in;
    end else if (grant_rd) begin
      mem_access_en_out = 1'b1;
      mem_set_addr_out  = read_req_addr_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q         <= ST_INIT;
      init_cnt_q      <= '0;
      init_done_q     <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      inflight_q <= grant_rd;
      if (grant_rd) inflight_addr_q <= read_req_addr_in;
      if (state_q == ST_INIT) begin
        init_cnt_q <= init_cnt_q + 1'b1;
        if (init_cnt_q == SET_PTR_WIDTH_IN_BITS'(NUMBER_SET - 1)) begin
          state_q     <= ST_RUN;
          init_done_q <= 1'b1;
        end
      end
    end
  end

`ifndef SINGLE_PORT_LUTRAM_CTRL_WRITE_PRIORITY_EN
  always_ff @(posedge clk_in) begin
    if (!reset_in) rr_q <= RR_READ;
    else if (contested) rr_q <= ~rr_q;
  end
`endif

  // The lutram returns read data one edge after issue; it is paired with the issuing address here.
  assign resp_push.addr = inflight_addr_q;
  assign resp_push.data = mem_read_entry_in;

  single_port_lutram_ctrl_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (2)
  ) u_resp_fifo (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .in_vld   (inflight_q),
    .in_rdy   (resp_in_rdy),
    .in_dat   (resp_push),
    .out_vld  (read_resp_valid_out),
    .out_rdy  (read_resp_ready_in),
    .out_dat  (resp_head),
    .count    (resp_count)
  );

  assign read_resp_addr_out = resp_head.addr;
  assign read_resp_data_out = resp_head.data;

  a_no_resp_overflow: assert property (@(posedge clk_in) disable iff (!reset_in) inflight_q |-> resp_in_rdy);
endmodule

// File: tb/tb_single_port_lutram_ctrl.sv
// Bench for single_port_lutram_ctrl: lutram model, table-driven transactions, directed corner sequences,
// and a random phase scored against a shadow-memory/response-queue reference model.
module tb_single_port_lutram_ctrl;
  localparam int DW = 64;
  localparam int NS = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done;
  logic          wr_v = 1'b0;
  logic          wr_rdy;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_dat = '0;
  logic          rd_v = 1'b0;
  logic          rd_rdy;
  logic [AW-1:0] rd_addr = '0;
  logic          resp_v;
  logic          resp_rdy = 1'b1;
  logic [AW-1:0] resp_addr;
  logic [DW-1:0] resp_dat;
  logic          acc;
  logic          we;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mentry;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] ram [NS];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  single_port_lutram_ctrl #(
    .SINGLE_ENTRY_SIZE_IN_BITS (DW),
    .NUMBER_SET                (NS)
  ) dut (
    .clk_in              (clk),
    .reset_in            (rst_n),
    .init_done_out       (init_done),
    .write_req_valid_in  (wr_v),
    .write_req_ready_out (wr_rdy),
    .write_req_addr_in   (wr_addr),
    .write_req_data_in   (wr_dat),
    .read_req_valid_in   (rd_v),
    .read_req_ready_out  (rd_rdy),
    .read_req_addr_in    (rd_addr),
    .read_resp_valid_out (resp_v),
    .read_resp_ready_in  (resp_rdy),
    .read_resp_addr_out  (resp_addr),
    .read_resp_data_out  (resp_dat),
    .mem_access_en_out   (acc),
    .mem_write_en_out    (we),
    .mem_set_addr_out    (maddr),
    .mem_write_entry_out (mentry),
    .mem_read_entry_in   (ram_q)
  );

  // single_port_lutram: write or registered read, one access per edge.
  always @(posedge clk) begin
    if (acc) begin
      if (we) ram[maddr] <= mentry;
      else    ram_q <= ram[maddr];
    end
  end

  task automatic check(input string nm, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model: grants follow arbitration rules on outstanding read count; data from shadow memory.
  logic [DW-1:0]    shadow [NS];
  logic [AW+DW-1:0] exp_q [$];
  logic [AW+DW-1:0] m_e;
  logic             m_pop, m_room, m_rd_can, m_ew, m_er;
  logic             m_next_rd = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < NS; i++) shadow[i] = '0;
      m_next_rd = 1'b1;
      check("rst_no_ready", {wr_rdy, rd_rdy}, 2'b00);
    end else if (!init_done) begin
      check("init_no_ready", {wr_rdy, rd_rdy}, 2'b00);
    end else begin
      m_pop  = resp_v && resp_rdy;
      m_room = (exp_q.size() - int'(m_pop)) < 2;
      if (m_pop) begin
        check("resp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          m_e = exp_q.pop_front();
          check("resp_entry", {resp_addr, resp_dat}, m_e);
        end
      end
      m_rd_can = rd_v && m_room;
      if (wr_v && m_rd_can) begin
`ifdef SINGLE_PORT_LUTRAM_CTRL_WRITE_PRIORITY_EN
        m_ew = 1'b1;
        m_er = 1'b0;
`else
        m_er      = m_next_rd;
        m_ew      = !m_next_rd;
        m_next_rd = !m_next_rd;
`endif
      end else begin
        m_ew = wr_v;
        m_er = m_rd_can;
      end
      check("grant", {wr_rdy, rd_rdy}, {m_ew, m_er});
      if (wr_v && wr_rdy)      check("mem_pins_wr", {acc, we, maddr, mentry}, {2'b11, wr_addr, wr_dat});
      else if (rd_v && rd_rdy) check("mem_pins_rd", {acc, we, maddr}, {2'b10, rd_addr});
      else                     check("mem_pins_idle", {acc, we, maddr, mentry}, '0);
      if (wr_v && wr_rdy) shadow[wr_addr] = wr_dat;
      if (rd_v && rd_rdy) exp_q.push_back({rd_addr, shadow[rd_addr]});
    end
  end

  task automatic check_sweep();
    wr_v = 1'b1;
    rd_v = 1'b1;
    for (int i = 0; i < NS; i++) begin
      wr_addr = AW'($urandom);
      rd_addr = AW'($urandom);
      @(negedge clk);
      check("sweep_cycle", {acc, we, wr_rdy, rd_rdy, init_done, resp_v, maddr, mentry, resp_addr, resp_dat},
            {6'b110000, AW'(i), 64'd0, 6'd0, 64'd0});
      @(posedge clk); #1;
    end
    wr_v = 1'b0;
    rd_v = 1'b0;
    @(negedge clk);
    check("sweep_done", {init_done, acc}, 2'b10);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    wr_v = 1'b1; wr_addr = a; wr_dat = d;
    for (int k = 0; k < 16 && !ok; k++) begin @(negedge clk); ok = wr_rdy; end
    check("wr_accept", ok, 1'b1);
    @(posedge clk); #1;
    wr_v = 1'b0;
  endtask

  task automatic do_read(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bit ok;
    ok = 1'b0;
    rd_v = 1'b1; rd_addr = a;
    for (int k = 0; k < 16 && !ok; k++) begin @(negedge clk); ok = rd_rdy; end
    check({nm, "_accept"}, ok, 1'b1);
    @(posedge clk); #1;
    rd_v = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin @(negedge clk); ok = resp_v; end
    check({nm, "_resp"}, {ok, resp_addr, resp_dat}, {1'b1, a, exp});
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;   // write data, or expected read data
  } vec_t;

  vec_t          vt [10];
  string         cexp;
  int            whold;
  byte           g;
  logic [DW-1:0] cresp [$];
  logic [DW-1:0] cresp_exp [$];
  logic [AW-1:0] bpaddr [$];

  initial begin
    vt[0] = '{1'b1, 6'd63, 64'hFFFFFFFF00000000};
    vt[1] = '{1'b0, 6'd63, 64'hFFFFFFFF00000000};
    vt[2] = '{1'b0, 6'd5,  64'h0};
    vt[3] = '{1'b1, 6'd5,  64'h0123456789ABCDEF};
    vt[4] = '{1'b1, 6'd0,  64'hDEADBEEFCAFEF00D};
    vt[5] = '{1'b0, 6'd5,  64'h0123456789ABCDEF};
    vt[6] = '{1'b0, 6'd0,  64'hDEADBEEFCAFEF00D};
    vt[7] = '{1'b1, 6'd5,  64'h5555AAAA5555AAAA};
    vt[8] = '{1'b0, 6'd5,  64'h5555AAAA5555AAAA};
    vt[9] = '{1'b0, 6'd62, 64'h0};
    for (int i = 0; i < NS; i++) ram[i] = {$urandom, $urandom};
    ram_q = {$urandom, $urandom};

    // Reset and initial zero-fill sweep.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {init_done, resp_v, resp_addr, resp_dat}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_sweep();

    // Table-driven single transactions.
    for (int i = 0; i < 10; i++) begin
      if (vt[i].is_wr) do_write(vt[i].addr, vt[i].dat);
      else             do_read($sformatf("vec%0d", i), vt[i].addr, vt[i].dat);
    end

    // Contention on address 1.
`ifdef SINGLE_PORT_LUTRAM_CTRL_WRITE_PRIORITY_EN
    cexp = "WWWR"; whold = 3; cresp_exp = '{64'h00000000FFFFFFFF};
`else
    cexp = "RWRW"; whold = 4; cresp_exp = '{64'h0, 64'h00000000FFFFFFFF};
`endif
    resp_rdy = 1'b1;
    rd_v = 1'b1; rd_addr = 6'd1;
    wr_addr = 6'd1; wr_dat = 64'h00000000FFFFFFFF;
    for (int c = 0; c < 4; c++) begin
      wr_v = (c < whold);
      @(negedge clk);
      g = wr_rdy ? "W" : (rd_rdy ? "R" : "-");
      check($sformatf("contend_grant%0d", c), g, cexp[c]);
      if (resp_v) cresp.push_back(resp_dat);
      @(posedge clk); #1;
    end
    wr_v = 1'b0; rd_v = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_v) cresp.push_back(resp_dat);
      @(posedge clk); #1;
    end
    check("contend_resp_count", cresp.size(), cresp_exp.size());
    for (int i = 0; i < cresp_exp.size() && i < cresp.size(); i++)
      check($sformatf("contend_resp%0d", i), cresp[i], cresp_exp[i]);

    // Backpressure: third read waits for the first pop and is accepted in that cycle.
    do_write(6'd10, 64'h1010101010101010);
    do_write(6'd11, 64'h1111111111111111);
    do_write(6'd12, 64'h1212121212121212);
    resp_rdy = 1'b0;
    rd_v = 1'b1;
    rd_addr = 6'd10; @(negedge clk); check("bp_rd0_ready", rd_rdy, 1'b1); @(posedge clk); #1;
    rd_addr = 6'd11; @(negedge clk); check("bp_rd1_ready", rd_rdy, 1'b1); @(posedge clk); #1;
    rd_addr = 6'd12; @(negedge clk); check("bp_rd2_blocked", rd_rdy, 1'b0); @(posedge clk); #1;
    @(negedge clk);
    check("bp_full_hold", {rd_rdy, resp_v, resp_addr}, {1'b0, 1'b1, 6'd10});
    @(posedge clk); #1;
    resp_rdy = 1'b1;
    @(negedge clk);
    check("bp_rd2_on_pop", {rd_rdy, resp_addr}, {1'b1, 6'd10});
    bpaddr.push_back(resp_addr);
    @(posedge clk); #1;
    rd_v = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_v) bpaddr.push_back(resp_addr);
      @(posedge clk); #1;
    end
    check("bp_pop_count", bpaddr.size(), 3);
    for (int i = 0; i < 3 && i < bpaddr.size(); i++)
      check($sformatf("bp_pop_order%0d", i), bpaddr[i], AW'(10 + i));

    // Reset with one response buffered and one read in flight.
    do_write(6'd20, 64'hA5A5A5A5A5A5A5A5);
    resp_rdy = 1'b0;
    rd_v = 1'b1;
    rd_addr = 6'd21; @(negedge clk); check("rst_rd0_ready", rd_rdy, 1'b1); @(posedge clk); #1;
    rd_addr = 6'd22; @(negedge clk); check("rst_rd1_ready", rd_rdy, 1'b1); @(posedge clk); #1;
    rd_v = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_pre_buffered", resp_v, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_rdy = 1'b1;
    check_sweep();
    do_read("post_rst", 6'd20, 64'h0);

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      wr_v     = ($urandom_range(0, 2) != 0);
      rd_v     = ($urandom_range(0, 2) != 0);
      wr_addr  = AW'($urandom_range(0, 7));
      rd_addr  = AW'($urandom_range(0, 7));
      wr_dat   = {$urandom, $urandom};
      resp_rdy = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    wr_v = 1'b0; rd_v = 1'b0; resp_rdy = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/single_port_lutram_ctrl.md
Name: single_port_lutram_ctrl

Overview:
Request front end that sits directly upstream of single_port_lutram and drives its access_en/write_en/set_addr/write_entry pins.
- Accepts independent valid/ready write and read request channels, arbitrates them onto the single memory port, and returns read data on a backpressurable response channel.
- Zero-fills every set after reset before accepting traffic.

Parameters:
SINGLE_ENTRY_SIZE_IN_BITS, 64, width of one entry
NUMBER_SET, 64, number of sets; must be a power of two
SET_PTR_WIDTH_IN_BITS, $clog2(NUMBER_SET), set address width

Ports:
clk_in  input  1  clock; all state updates on rising edge
reset_in  input  1  synchronous, active-low reset
init_done_out  output  1  high once the zero-fill sweep has completed
write_req_valid_in  input  1  write request valid
write_req_ready_out  output  1  write request accepted this cycle when valid also high
write_req_addr_in  input  SET_PTR_WIDTH_IN_BITS  write set address
write_req_data_in  input  SINGLE_ENTRY_SIZE_IN_BITS  write data
read_req_valid_in  input  1  read request valid
read_req_ready_out  output  1  read request accepted this cycle when valid also high
read_req_addr_in  input  SET_PTR_WIDTH_IN_BITS  read set address
read_resp_valid_out  output  1  response buffer head valid
read_resp_ready_in  input  1  consumer takes the head
read_resp_addr_out  output  SET_PTR_WIDTH_IN_BITS  address of the returned entry
read_resp_data_out  output  SINGLE_ENTRY_SIZE_IN_BITS  returned entry
mem_access_en_out  output  1  to lutram access_en_in
mem_write_en_out  output  1  to lutram write_en_in
mem_set_addr_out  output  SET_PTR_WIDTH_IN_BITS  to lutram access_set_addr_in
mem_write_entry_out  output  SINGLE_ENTRY_SIZE_IN_BITS  to lutram write_entry_in
mem_read_entry_in  input  SINGLE_ENTRY_SIZE_IN_BITS  from lutram read_entry_out

Behaviour:
Reset:
- reset_in==0 at a rising edge sets state=INIT, init counter=0, response buffer empty, in-flight flag=0, round-robin pointer=READ.
- Registered outputs after reset: init_done_out=0, read_resp_valid_out=0; read_resp_addr/data_out hold 0.
- Requests are not accepted while reset_in==0.

FSM INIT:
- Every cycle drive mem_access_en=1, mem_write_en=1, mem_set_addr=counter, mem_write_entry=0.
- Counter increments; after addr NUMBER_SET-1 is written, go to RUN.
- Both ready outputs are 0 throughout INIT.
- Sweep takes exactly NUMBER_SET cycles; init_done_out rises on the next edge and stays high until reset.

FSM RUN:
- At most one memory operation per cycle.
- read_ok = (buffer occupancy + in-flight - pop_this_cycle) < 2, where pop = read_resp_valid_out & read_resp_ready_in. This combinational path from read_resp_ready_in to read_req_ready_out is intended.
- Grant:
  - Only write valid: write.
  - Only read valid and read_ok: read.
  - Both valid and read_ok: the round-robin pointer chooses; the pointer flips to the other side after each contested grant.
  - Both valid and !read_ok: write, and the pointer is unchanged.
- ready outputs equal the grant, and may depend on the other channel's valid.
- Memory pins are combinational from the grant: mem_access_en=fire, mem_write_en=write fire, mem_set_addr/mem_write_entry taken from the granted request. Idle cycles drive all 0.

Read path:
- Memory latency is fixed at 1 cycle: mem_read_entry_in is sampled on the edge after issue.
- The sampled data is pushed, together with the issuing address, into a 2-entry response FIFO.
- Head is presented on read_resp_*; pop on valid&ready.
- Sustained 1 read/cycle with read_resp_ready_in held high.
- Ordering: a same-address write granted before a read is visible to that read, because grant order equals memory order.

Boundaries:
- FIFO full plus a new read request gives read_req_ready_out=0.
- Simultaneous push and pop on a full buffer is legal.
- Reset mid-operation: the in-flight read and buffered responses are discarded, and the zero-fill sweep restarts.
- NUMBER_SET not a power of two: simulation $error at time 0.

Optional Feature:
- Macro: SINGLE_PORT_LUTRAM_CTRL_WRITE_PRIORITY_EN.
- Defined: contested cycles always grant write; the round-robin pointer is removed; reads are granted only with no write valid.
- Undefined: round-robin as above.
- Ports and latency are identical in both builds.

Test Plan:
- Init sweep: release reset with NUMBER_SET=64 -> mem_access_en=mem_write_en=1 for exactly 64 cycles with addr 0..63 and data 0; init_done_out=1 on the next cycle; readies 0 throughout.
- Write then read: write 0xFFFFFFFF00000000 to addr 63, then read addr 63 -> read_resp_valid 1 cycle after read grant, data 0xFFFFFFFF00000000, addr 63. A read of addr 5 returns 0.
- Contention: write (addr 1, 0x00000000FFFFFFFF) and read (addr 1) both held valid for 4 cycles -> grants alternate R,W,R,W; the second read returns 0x00000000FFFFFFFF, the first returns 0.
- Backpressure: read_resp_ready_in=0, three back-to-back reads -> two accepted, third sees read_req_ready_out=0. Raising ready pops in order and the third is accepted in the same cycle as the first pop.
- Reset mid-run: assert reset_in=0 for one cycle with one read in flight and one buffered -> read_resp_valid_out=0, init_done_out=0, a 64-cycle re-sweep follows, and a prior write is read back as 0.
- With SINGLE_PORT_LUTRAM_CTRL_WRITE_PRIORITY_EN: both channels valid for 3 cycles -> three write grants, no read grant until write_req_valid_in drops.
